// File: rtl/cv_core_stream.sv
`default_nettype none
// -----------------------------------------------------------------------------
// cv_core_stream : raster frame scanner applying a per-frame pixel operation
//                  (pass / threshold / invert / 1-2-1 horizontal blur).
// Revision       : 1.0  initial parametrised release
// -----------------------------------------------------------------------------
module cv_core_stream #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int H_MAX      = 800,
  parameter int V_MAX      = 525,
  parameter int IN_BITS    = 8,
  parameter int OUT_BITS   = 4,
  parameter int ADDR_BITS  = 19,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic                 clk24,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [IN_BITS-1:0]   thresh,
  input  logic [IN_BITS-1:0]   din,
  output logic [ADDR_BITS-1:0] addr_mem0,
  output logic [ADDR_BITS-1:0] addr_mem1,
  output logic [OUT_BITS-1:0]  dout,
  output logic                 we,
  output logic                 busy,
  output logic                 core_end
);

  localparam int HW = $clog2(H_MAX);
  localparam int VW = $clog2(V_MAX + 1);
  localparam int SW = IN_BITS + 2;

  localparam logic [HW-1:0]        H_LAST    = HW'(H_MAX - 1);
  localparam logic [HW-1:0]        H_ACT     = HW'(WIDTH);
  localparam logic [HW-1:0]        C_LAST    = HW'(WIDTH - 1);
  localparam logic [VW-1:0]        V_LAST    = VW'(V_MAX - 1);
  localparam logic [VW-1:0]        V_ACT     = VW'(HEIGHT);
  localparam logic [ADDR_BITS-1:0] LINE_STEP = ADDR_BITS'(WIDTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e                 state_q;
  logic [HW-1:0]          hor_q;
  logic [VW-1:0]          ver_q;
  logic [ADDR_BITS-1:0]   base_q;
  logic [1:0]             mode_q;
  logic [IN_BITS-1:0]     thresh_q;

  logic                   active_d;
  logic                   last_d;

  // Pipeline: stage 0 tracks the address in flight, stage 1 holds p(c).
  logic                   v0_q, v1_q;
  logic [HW-1:0]          col0_q, col1_q;
  logic [ADDR_BITS-1:0]   a0_q, a1_q;
  logic [IN_BITS-1:0]     pc_q, pl_q;

  logic                   we_q;
  logic [OUT_BITS-1:0]    dout_q;
  logic [ADDR_BITS-1:0]   addr1_q;

  logic [IN_BITS-1:0]     left_d, right_d;
  logic [SW-1:0]          sum_d;
  logic [OUT_BITS-1:0]    res_d;

  assign active_d  = (state_q == S_RUN) && (hor_q < H_ACT) && (ver_q < V_ACT);
  assign last_d    = (state_q == S_RUN) && (hor_q == H_LAST) && (ver_q == V_LAST);
  assign addr_mem0 = active_d ? (base_q + ADDR_BITS'(hor_q)) : '0;

  assign busy      = (state_q == S_RUN);
  assign core_end  = last_d;
  assign we        = we_q;
  assign dout      = dout_q;
  assign addr_mem1 = addr1_q;

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      hor_q    <= '0;
      ver_q    <= '0;
      base_q   <= '0;
      mode_q   <= '0;
      thresh_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_RUN;
            mode_q   <= mode;
            thresh_q <= thresh;
            hor_q    <= '0;
            ver_q    <= '0;
            base_q   <= '0;
          end
        end
        default: begin
          if (last_d) begin
            hor_q  <= '0;
            ver_q  <= '0;
            base_q <= '0;
            if (CONTINUOUS) begin
              mode_q   <= mode;
              thresh_q <= thresh;
            end else begin
              state_q  <= S_IDLE;
            end
          end else if (hor_q == H_LAST) begin
            hor_q  <= '0;
            ver_q  <= ver_q + VW'(1);
            base_q <= base_q + LINE_STEP;
          end else begin
            hor_q  <= hor_q + HW'(1);
          end
        end
      endcase
    end
  end

  // Blur neighbours: din already carries p(c+1); edges replicate the centre.
  always_comb begin
    left_d  = (col1_q == '0)     ? pc_q : pl_q;
    right_d = (col1_q == C_LAST) ? pc_q : din;
    sum_d   = {2'b00, left_d} + {1'b0, pc_q, 1'b0} + {2'b00, right_d} + SW'(2);
    res_d   = '0;
    case (mode_q)
      2'd0:    res_d = pc_q[IN_BITS-1 -: OUT_BITS];
      2'd1:    res_d = (pc_q >= thresh_q) ? {OUT_BITS{1'b1}} : '0;
      2'd2:    res_d = ~pc_q[IN_BITS-1 -: OUT_BITS];
      default: res_d = sum_d[SW-1 -: OUT_BITS];
    endcase
  end

  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      col0_q  <= '0;
      col1_q  <= '0;
      a0_q    <= '0;
      a1_q    <= '0;
      pc_q    <= '0;
      pl_q    <= '0;
      we_q    <= 1'b0;
      dout_q  <= '0;
      addr1_q <= '0;
    end else begin
      v0_q   <= active_d;
      col0_q <= hor_q;
      a0_q   <= addr_mem0;
      v1_q   <= v0_q;
      col1_q <= col0_q;
      a1_q   <= a0_q;
      pc_q   <= din;
      pl_q   <= pc_q;
      we_q   <= v1_q;
      if (v1_q) begin
        dout_q  <= res_d;
        addr1_q <= a1_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cv_core_stream.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_cv_core_stream : self-checking bench for cv_core_stream (4x2 active, 8x3).
// Revision          : 1.0
// -----------------------------------------------------------------------------
module tb_cv_core_stream;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int HM = 8;
  localparam int VM = 3;
  localparam int AB = 19;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          start_c = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [7:0]    thresh = 8'd0;
  logic [7:0]    din, din_c;
  logic [AB-1:0] addr_mem0, addr_mem1, c_addr_mem0, c_addr_mem1;
  logic [3:0]    dout, c_dout;
  logic          we, busy, core_end, c_we, c_busy, c_core_end;

  logic [7:0]    mem [0:7];
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;

  int wa[$], wd[$], wt[$], ct[$], bh;
  int cwa[$], cwd[$], cwt[$], cct[$];

  always #5 clk = ~clk;

  cv_core_stream #(
    .WIDTH(W), .HEIGHT(H), .H_MAX(HM), .V_MAX(VM),
    .IN_BITS(8), .OUT_BITS(4), .ADDR_BITS(AB), .CONTINUOUS(1'b0)
  ) dut (
    .clk24(clk), .rst_n(rst_n), .start(start), .mode(mode), .thresh(thresh),
    .din(din), .addr_mem0(addr_mem0), .addr_mem1(addr_mem1), .dout(dout),
    .we(we), .busy(busy), .core_end(core_end)
  );

  cv_core_stream #(
    .WIDTH(W), .HEIGHT(H), .H_MAX(HM), .V_MAX(VM),
    .IN_BITS(8), .OUT_BITS(4), .ADDR_BITS(AB), .CONTINUOUS(1'b1)
  ) dut_c (
    .clk24(clk), .rst_n(rst_n), .start(start_c), .mode(mode), .thresh(thresh),
    .din(din_c), .addr_mem0(c_addr_mem0), .addr_mem1(c_addr_mem1), .dout(c_dout),
    .we(c_we), .busy(c_busy), .core_end(c_core_end)
  );

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    din   <= mem[addr_mem0[2:0]];
    din_c <= mem[c_addr_mem0[2:0]];
  end

  always @(negedge clk) begin
    if (we)         begin wa.push_back(int'(addr_mem1)); wd.push_back(int'(dout)); wt.push_back(cyc); end
    if (core_end)   ct.push_back(cyc);
    if (busy)       bh++;
    if (c_we)       begin cwa.push_back(int'(c_addr_mem1)); cwd.push_back(int'(c_dout)); cwt.push_back(cyc); end
    if (c_core_end) cct.push_back(cyc);
  end

  // Reference pixel operation straight from the operation rules.
  function automatic int model_px(int m, int th, int a);
    int p, c, l, r;
    p = int'(mem[a]);
    c = a % W;
    case (m)
      0: return p / 16;
      1: return (p >= th) ? 15 : 0;
      2: return 15 - p / 16;
      default: begin
        l = (c == 0) ? p : int'(mem[a-1]);
        r = (c == W-1) ? p : int'(mem[a+1]);
        return ((l + 2*p + r + 2) / 4) / 16;
      end
    endcase
  endfunction

  task automatic fill_formula();
    for (int i = 0; i < 8; i++) mem[i] = 8'(i * 16 + 5);
  endtask

  task automatic run_frame(input logic [1:0] m, input logic [7:0] th, output int s, output bit ok);
    wa.delete(); wd.delete(); wt.delete(); ct.delete(); bh = 0;
    mode = m; thresh = th;
    @(negedge clk); s = cyc; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk); #1;
      if (ct.size() > 0) ok = 1'b1;
    end
    repeat (6) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (we !== 1'b0 || busy !== 1'b0 || core_end !== 1'b0)
      begin bad++; $display("FAIL reset_ctrl: got we=%b busy=%b core_end=%b, want 0 0 0", we, busy, core_end); end
    total++; if (dout !== 4'h0 || addr_mem1 !== '0 || addr_mem0 !== '0)
      begin bad++; $display("FAIL reset_data: got dout=%0h addr1=%0d addr0=%0d, want 0 0 0", dout, addr_mem1, addr_mem0); end
    total++; if (c_we !== 1'b0 || c_busy !== 1'b0 || c_dout !== 4'h0)
      begin bad++; $display("FAIL reset_cont: got we=%b busy=%b dout=%0h, want 0 0 0", c_we, c_busy, c_dout); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_pass();
    int s; bit ok;
    fill_formula();
    run_frame(2'd0, 8'd0, s, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL pass_timeout: core_end not seen within bound"); end
    total++; if (wa.size() != 8) begin bad++; $display("FAIL pass_count: got %0d writes, want 8", wa.size()); end
    for (int i = 0; i < wa.size() && i < 8; i++) begin
      total++;
      if (wa[i] != i || wd[i] != i || wt[i] - s != 4 + (i / W) * HM + (i % W))
        begin bad++; $display("FAIL pass_write[%0d]: got addr=%0d dout=%0h cyc=%0d, want addr=%0d dout=%0h cyc=%0d",
                              i, wa[i], wd[i], wt[i] - s, i, i, 4 + (i / W) * HM + (i % W)); end
    end
    total++; if (ct.size() != 1 || ct[0] - s != 24)
      begin bad++; $display("FAIL pass_core_end: got %0d pulses first at %0d, want 1 at 24", ct.size(), (ct.size() > 0) ? ct[0] - s : -1); end
    total++; if (bh != 24 || busy !== 1'b0)
      begin bad++; $display("FAIL pass_busy: got high cycles=%0d busy_now=%b, want 24 0", bh, busy); end
  endtask

  task automatic test_threshold();
    int s; bit ok;
    int exp_d[8] = '{0, 0, 0, 0, 15, 15, 15, 15};
    fill_formula();
    run_frame(2'd1, 8'h40, s, ok);
    total++; if (ok !== 1'b1 || wa.size() != 8)
      begin bad++; $display("FAIL thr_count: got %0d writes ok=%b, want 8 1", wa.size(), ok); end
    for (int i = 0; i < wa.size() && i < 8; i++) begin
      total++; if (wa[i] != i || wd[i] != exp_d[i])
        begin bad++; $display("FAIL thr_write[%0d]: got addr=%0d dout=%0h, want addr=%0d dout=%0h", i, wa[i], wd[i], i, exp_d[i]); end
    end
  endtask

  task automatic test_invert();
    int s; bit ok;
    fill_formula();
    run_frame(2'd2, 8'd0, s, ok);
    total++; if (ok !== 1'b1 || wa.size() != 8)
      begin bad++; $display("FAIL inv_count: got %0d writes ok=%b, want 8 1", wa.size(), ok); end
    for (int i = 0; i < wa.size() && i < 8; i++) begin
      total++; if (wa[i] != i || wd[i] != 15 - i)
        begin bad++; $display("FAIL inv_write[%0d]: got addr=%0d dout=%0h, want addr=%0d dout=%0h", i, wa[i], wd[i], i, 15 - i); end
    end
  endtask

  task automatic test_blur();
    int s; bit ok;
    fill_formula();
    run_frame(2'd3, 8'd0, s, ok);
    total++; if (ok !== 1'b1 || wa.size() != 8)
      begin bad++; $display("FAIL blur_count: got %0d writes ok=%b, want 8 1", wa.size(), ok); end
    for (int i = 0; i < wa.size() && i < 8; i++) begin
      total++; if (wa[i] != i || wd[i] != i || wt[i] - s != 4 + (i / W) * HM + (i % W))
        begin bad++; $display("FAIL blur_write[%0d]: got addr=%0d dout=%0h cyc=%0d, want addr=%0d dout=%0h", i, wa[i], wd[i], wt[i] - s, i, i); end
    end
  endtask

  task automatic test_random();
    int s; bit ok;
    logic [1:0] m;
    logic [7:0] th;
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < 8; i++) mem[i] = 8'($urandom_range(0, 255));
      m  = 2'($urandom_range(0, 3));
      th = 8'($urandom_range(0, 255));
      run_frame(m, th, s, ok);
      total++; if (ok !== 1'b1 || wa.size() != 8)
        begin bad++; $display("FAIL rand_count[%0d]: got %0d writes ok=%b, want 8 1", it, wa.size(), ok); end
      for (int i = 0; i < wa.size() && i < 8; i++) begin
        total++; if (wa[i] != i || wd[i] != model_px(int'(m), int'(th), i))
          begin bad++; $display("FAIL rand_write[%0d.%0d]: mode=%0d got addr=%0d dout=%0h, want addr=%0d dout=%0h",
                                it, i, m, wa[i], wd[i], i, model_px(int'(m), int'(th), i)); end
      end
    end
  endtask

  task automatic test_start_ignored();
    int s;
    fill_formula();
    wa.delete(); wd.delete(); wt.delete(); ct.delete();
    mode = 2'd0; thresh = 8'd0;
    @(negedge clk); s = cyc; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (i == 8) begin mode = 2'd2; thresh = 8'hFF; start = 1'b1; end
      else start = 1'b0;
    end
    total++; if (wa.size() != 8 || ct.size() != 1 || busy !== 1'b0)
      begin bad++; $display("FAIL ign_count: got writes=%0d core_end=%0d busy=%b, want 8 1 0", wa.size(), ct.size(), busy); end
    for (int i = 0; i < wa.size() && i < 8; i++) begin
      total++; if (wa[i] != i || wd[i] != i)
        begin bad++; $display("FAIL ign_write[%0d]: got addr=%0d dout=%0h, want addr=%0d dout=%0h", i, wa[i], wd[i], i, i); end
    end
  endtask

  task automatic test_continuous();
    int s, low, n2;
    bit ok;
    fill_formula();
    cwa.delete(); cwd.delete(); cwt.delete(); cct.delete();
    mode = 2'd0; thresh = 8'd0; low = 0;
    @(negedge clk); s = cyc; start_c = 1'b1;
    @(negedge clk); start_c = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk); #1;
      if (!c_busy) low++;
      if (i == 9) mode = 2'd2;
      start_c = (i == 14 || i == 30);
      if (cct.size() >= 2) ok = 1'b1;
    end
    start_c = 1'b0;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL cont_timeout: got %0d core_end pulses, want 2", cct.size()); end
    if (ok) begin
      total++; if (cct[0] - s != 24 || cct[1] - cct[0] != 24)
        begin bad++; $display("FAIL cont_period: got ends at %0d/%0d, want 24/48", cct[0] - s, cct[1] - s); end
      n2 = 0;
      foreach (cwt[i]) if (cwt[i] <= cct[1]) n2++;
      total++; if (n2 != 16) begin bad++; $display("FAIL cont_count: got %0d writes, want 16", n2); end
      total++; if (cwt.size() < 9 || cwt[8] - cct[0] != 4)
        begin bad++; $display("FAIL cont_gap: got frame2 first write at %0d after core_end, want 4", (cwt.size() > 8) ? cwt[8] - cct[0] : -1); end
      for (int i = 0; i < 16 && i < cwa.size(); i++) begin
        total++; if (cwa[i] != i % 8 || cwd[i] != ((i < 8) ? i : 15 - (i % 8)))
          begin bad++; $display("FAIL cont_write[%0d]: got addr=%0d dout=%0h, want addr=%0d dout=%0h",
                                i, cwa[i], cwd[i], i % 8, (i < 8) ? i : 15 - (i % 8)); end
      end
    end
    total++; if (low != 0 || c_busy !== 1'b1)
      begin bad++; $display("FAIL cont_busy: got low cycles=%0d busy_now=%b, want 0 1", low, c_busy); end
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mode = 2'd0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    int s; bit ok;
    fill_formula();
    wa.delete(); wd.delete(); wt.delete(); ct.delete();
    mode = 2'd0; thresh = 8'd0;
    @(negedge clk); s = cyc; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20 && cyc < s + 10; i++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (we !== 1'b0 || busy !== 1'b0 || addr_mem0 !== '0)
      begin bad++; $display("FAIL rst_mid_ctrl: got we=%b busy=%b addr0=%0d, want 0 0 0", we, busy, addr_mem0); end
    total++; if (dout !== 4'h0 || addr_mem1 !== '0)
      begin bad++; $display("FAIL rst_mid_data: got dout=%0h addr1=%0d, want 0 0", dout, addr_mem1); end
    total++; if (wa.size() != 4) begin bad++; $display("FAIL rst_mid_pre: got %0d writes before reset, want 4", wa.size()); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wa.delete(); wd.delete();
    repeat (40) @(negedge clk);
    #1;
    total++; if (wa.size() != 0 || busy !== 1'b0)
      begin bad++; $display("FAIL rst_mid_quiet: got writes=%0d busy=%b, want 0 0", wa.size(), busy); end
    run_frame(2'd0, 8'd0, s, ok);
    total++; if (ok !== 1'b1 || wa.size() != 8)
      begin bad++; $display("FAIL rst_mid_restart: got %0d writes ok=%b, want 8 1", wa.size(), ok); end
    for (int i = 0; i < wa.size() && i < 8; i++) begin
      total++; if (wa[i] != i || wd[i] != i)
        begin bad++; $display("FAIL rst_mid_write[%0d]: got addr=%0d dout=%0h, want addr=%0d dout=%0h", i, wa[i], wd[i], i, i); end
    end
  endtask

  initial begin
    fill_formula();
    test_reset();
    test_pass();
    test_threshold();
    test_invert();
    test_blur();
    test_random();
    test_start_ignored();
    test_continuous();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
